// File: rtl/serial_frame_tx_if.sv
// Request/serial-line bundle for serial_frame_tx: parallel request side plus
// the serial line and status flags.
interface serial_frame_tx_if #(
  parameter int LEN_W = 4
) ();
  localparam int DATA_W = (1 << LEN_W) - 1;

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              sout;
  logic              busy;
  logic              done;

  modport master (
    output start, len, data,
    input  ready, sout, busy, done
  );

  modport slave (
    input  start, len, data,
    output ready, sout, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, MSB-first length field, MSB-first payload,
// followed by a one-cycle done pulse. All outputs are registered.
module serial_frame_tx #(
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_frame_tx_if.slave  bus
);
  localparam int DATA_W = (1 << LEN_W) - 1;
  localparam logic [LEN_W-1:0] CNT_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_TOP  = LEN_W'(LEN_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [LEN_W-1:0]   cnt_r;
  logic [LEN_W-1:0]   cnt_s;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   len_s;
  logic [DATA_W-1:0]  data_r;
  logic [DATA_W-1:0]  data_s;
  logic               sout_r;
  logic               sout_s;
  logic               busy_r;
  logic               ready_r;
  logic               done_r;

  function automatic logic pick_len(input logic [LEN_W-1:0] v, input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < LEN_W; i++) begin
      b = (idx == LEN_W'(i)) ? v[i] : b;
    end
    return b;
  endfunction

  function automatic logic pick_data(input logic [DATA_W-1:0] v, input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      b = (idx == LEN_W'(i)) ? v[i] : b;
    end
    return b;
  endfunction

  // Next-state, counter and capture logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    len_s   = len_r;
    data_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_START;
          len_s   = bus.len;
          data_s  = bus.data;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_s = ST_LEN;
        cnt_s   = CNT_TOP;
      end
      ST_LEN: begin
        if (cnt_r == CNT_ZERO) begin
          // len-1 is only formed for a non-zero length, so the counter never wraps
          if (len_r == CNT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DATA;
            cnt_s   = len_r - CNT_ONE;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Line value for the upcoming cycle, so sout can be a plain register.
  always_comb begin
    sout_s = 1'b0;
    case (state_s)
      ST_START: sout_s = 1'b1;
      ST_LEN:   sout_s = pick_len(len_s, cnt_s);
      ST_DATA:  sout_s = pick_data(data_s, cnt_s);
      default:  sout_s = 1'b0;
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      len_r   <= CNT_ZERO;
      data_r  <= {DATA_W{1'b0}};
      sout_r  <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
      data_r  <= data_s;
      sout_r  <= sout_s;
      busy_r  <= (state_s != ST_IDLE);
      ready_r <= (state_s == ST_IDLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign bus.sout  = sout_r;
  assign bus.busy  = busy_r;
  assign bus.ready = ready_r;
  assign bus.done  = done_r;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: directed and random frames compared
// against a bit-list model of the frame format.
module tb_serial_frame_tx;
  localparam int LEN_W  = 4;
  localparam int DATA_W = (1 << LEN_W) - 1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_frame_tx_if #(.LEN_W(LEN_W)) bus ();

  serial_frame_tx #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.len = 4'd5;
    bus.data = 15'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.sout !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset: sout=%b busy=%b ready=%b done=%b, want 0 0 1 0",
                 bus.sout, bus.busy, bus.ready, bus.done);
      end
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: busy=%b ready=%b, want 0 1", bus.busy, bus.ready);
    end
  endtask

  // Sends one frame, scrambles the request inputs after accept, and compares
  // the captured line against the model.
  task automatic send_frame(input int l, input logic [DATA_W-1:0] d, input string name);
    bit exp_q[$];
    logic sout_cap[64];
    logic done_cap[64];
    int n;
    int ndone;
    exp_q.push_back(1'b1);
    for (int i = LEN_W - 1; i >= 0; i--) exp_q.push_back(((l >> i) & 1) != 0);
    for (int i = l - 1; i >= 0; i--) exp_q.push_back(d[i]);
    exp_q.push_back(1'b0);

    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b want 1", name, bus.ready);
    end
    bus.start = 1'b1;
    bus.len = LEN_W'(l);
    bus.data = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len = LEN_W'($urandom);
    bus.data = DATA_W'($urandom);
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      sout_cap[n] = bus.sout;
      done_cap[n] = bus.done;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== LEN_W + l + 2) begin
      errors++;
      $display("FAIL %s occupancy: got %0d want %0d", name, n, LEN_W + l + 2);
    end
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      checks++;
      if (sout_cap[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s sout[%0d]: got %b want %b", name, k, sout_cap[k], exp_q[k]);
      end
    end
    ndone = 0;
    for (int k = 0; k < n; k++) if (done_cap[k] === 1'b1) ndone++;
    checks++;
    if (ndone != 1 || n == 0 || done_cap[(n > 0) ? n - 1 : 0] !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: count=%0d, want exactly 1 on last busy cycle", name, ndone);
    end
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.sout !== 1'b0) begin
      errors++;
      $display("FAIL %s after: ready=%b done=%b sout=%b, want 1 0 0", name, bus.ready, bus.done, bus.sout);
    end
  endtask

  task automatic test_directed();
    send_frame(3, 15'h0005, "len3_0005");
    send_frame(3, 15'h7FFA, "len3_7ffa");
    send_frame(0, 15'h7FFF, "len0");
    send_frame(15, 15'h5555, "len15");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      send_frame(int'($urandom_range(0, DATA_W)), DATA_W'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] pat;
    int wait_n;
    pat = 9'b100101100;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 4'd2;
    bus.data = 15'h0003;
    @(negedge clk);
    for (int k = 0; k < 27; k++) begin
      checks++;
      if (bus.sout !== pat[8 - (k % 9)] || bus.done !== ((k % 9) == 7)) begin
        errors++;
        $display("FAIL b2b[%0d]: sout=%b done=%b want sout=%b done=%b",
                 k, bus.sout, bus.done, pat[8 - (k % 9)], ((k % 9) == 7));
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_n = 0;
    while (bus.ready !== 1'b1 && wait_n < 40) begin
      wait_n++;
      @(negedge clk);
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: ready=%b want 1", bus.ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 4'd15;
    bus.data = DATA_W'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got %b want 1", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.sout !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: sout=%b busy=%b ready=%b done=%b, want 0 0 1 0",
               bus.sout, bus.busy, bus.ready, bus.done);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.sout !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet[%0d]: done=%b sout=%b want 0 0", k, bus.done, bus.sout);
      end
    end
    send_frame(15, 15'h4C3B, "post_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.data = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
